// File: rtl/sig_adder_norm.sv
// rtl/sig_adder_norm.sv - three-stage sum and normalize of four aligned signed lanes, two results per beat
// Optional feature macro SIG_ADDER_RNE_EN: round to nearest even instead of truncating toward zero.
module sig_adder_norm #(
  parameter int expWidth   = 4,
  parameter int sigWidth   = 4,
  parameter int low_expand = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [expWidth-1:0]                  max_exp,
  input  logic [4*(sigWidth+4+low_expand)-1:0] adder_num1,
  input  logic [4*(sigWidth+4+low_expand)-1:0] adder_num2,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [1:0]                           out_sign,
  output logic [2*expWidth-1:0]                out_exp,
  output logic [2*sigWidth-1:0]                out_sig,
  output logic [1:0]                           out_zero,
  output logic [1:0]                           out_ovf
);
  localparam int W    = sigWidth + 4 + low_expand;
  localparam int H    = sigWidth + low_expand;
  // Magnitude keeps one bit beyond W+1 so that four most-negative lanes still normalize correctly.
  localparam int MW   = W + 2;
  localparam int EW   = expWidth + 2;
  localparam int PW   = $clog2(MW);
  localparam int EMAX = (1 << expWidth) - 1;

  typedef struct packed {
    logic                sign;
    logic [expWidth-1:0] exp;
    logic [sigWidth-1:0] sig;
    logic                zero;
    logic                ovf;
  } res_t;

  logic                adv;
  logic [1:0][4*W-1:0] lanes;

  logic                s1_valid_q;
  logic [expWidth-1:0] s1_exp_q;
  logic [1:0][W:0]     s1_pa_q, s1_pb_q, s1_pa_d, s1_pb_d;

  logic                s2_valid_q;
  logic [expWidth-1:0] s2_exp_q;
  logic [1:0][MW-1:0]  s2_sum;
  logic [1:0]          s2_sign_q, s2_sign_d;
  logic [1:0][MW-1:0]  s2_mag_q, s2_mag_d;

  logic                out_valid_q;
  res_t [1:0]          res_q, res_d;

  function automatic res_t normalize(input logic sgn, input logic [MW-1:0] mag,
                                     input logic [expWidth-1:0] mexp);
    res_t                 r;
    logic [PW-1:0]        p;
    logic [MW-1:0]        nrm;
    logic [sigWidth-1:0]  sig;
    logic signed [EW-1:0] e;
`ifdef SIG_ADDER_RNE_EN
    logic                 guard;
    logic                 sticky;
    logic [sigWidth:0]    sig_r;
`endif
    p = '0;
    for (int i = 0; i < MW; i++) begin
      if (mag[i]) p = PW'(i);
    end
    nrm = mag << (PW'(MW - 1) - p);
    sig = nrm[MW-2 -: sigWidth];
    e   = EW'(mexp) + EW'(p) - EW'(H);
`ifdef SIG_ADDER_RNE_EN
    guard  = nrm[MW-2-sigWidth];
    sticky = |nrm[MW-3-sigWidth:0];
    sig_r  = {1'b0, sig} + {{sigWidth{1'b0}}, guard & (sticky | sig[0])};
    if (sig_r[sigWidth]) begin
      sig = '0;
      e   = e + EW'(1);
    end else begin
      sig = sig_r[sigWidth-1:0];
    end
`endif
    r = '0;
    if (mag == '0 || e < EW'(1)) begin
      r.zero = 1'b1;
    end else if (e > EW'(EMAX)) begin
      r.sign = sgn;
      r.exp  = '1;
      r.sig  = '1;
      r.ovf  = 1'b1;
    end else begin
      r.sign = sgn;
      r.exp  = e[expWidth-1:0];
      r.sig  = sig;
    end
    return r;
  endfunction

  assign adv      = ~out_valid_q | out_ready;
  assign in_ready = adv;
  assign lanes    = {adder_num2, adder_num1};

  always_comb begin
    s1_pa_d   = '0;
    s1_pb_d   = '0;
    s2_sum    = '0;
    s2_sign_d = '0;
    s2_mag_d  = '0;
    res_d     = '0;
    for (int k = 0; k < 2; k++) begin
      s1_pa_d[k]   = {lanes[k][W-1], lanes[k][0 +: W]} + {lanes[k][2*W-1], lanes[k][W +: W]};
      s1_pb_d[k]   = {lanes[k][3*W-1], lanes[k][2*W +: W]} + {lanes[k][4*W-1], lanes[k][3*W +: W]};
      s2_sum[k]    = {s1_pa_q[k][W], s1_pa_q[k]} + {s1_pb_q[k][W], s1_pb_q[k]};
      s2_sign_d[k] = s2_sum[k][MW-1];
      s2_mag_d[k]  = s2_sum[k][MW-1] ? -s2_sum[k] : s2_sum[k];
      res_d[k]     = normalize(s2_sign_q[k], s2_mag_q[k], s2_exp_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_exp_q    <= '0;
      s1_pa_q     <= '0;
      s1_pb_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_exp_q    <= '0;
      s2_sign_q   <= '0;
      s2_mag_q    <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
    end else if (adv) begin
      s1_valid_q  <= in_valid;
      s1_exp_q    <= max_exp;
      s1_pa_q     <= s1_pa_d;
      s1_pb_q     <= s1_pb_d;
      s2_valid_q  <= s1_valid_q;
      s2_exp_q    <= s1_exp_q;
      s2_sign_q   <= s2_sign_d;
      s2_mag_q    <= s2_mag_d;
      out_valid_q <= s2_valid_q;
      res_q       <= res_d;
    end
  end

  assign out_valid = out_valid_q;

  for (genvar k = 0; k < 2; k++) begin : g_out
    assign out_sign[k]                     = res_q[k].sign;
    assign out_exp[k*expWidth +: expWidth] = res_q[k].exp;
    assign out_sig[k*sigWidth +: sigWidth] = res_q[k].sig;
    assign out_zero[k]                     = res_q[k].zero;
    assign out_ovf[k]                      = res_q[k].ovf;
  end

endmodule

// File: tb/tb_sig_adder_norm.sv
// tb/tb_sig_adder_norm.sv - scoreboard bench for sig_adder_norm with directed vectors
// Expected values follow SIG_ADDER_RNE_EN when it is defined for the build.
module tb_sig_adder_norm;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  max_exp;
  logic [39:0] adder_num1;
  logic [39:0] adder_num2;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_sign;
  logic [7:0]  out_exp;
  logic [7:0]  out_sig;
  logic [1:0]  out_zero;
  logic [1:0]  out_ovf;

  int checks = 0;
  int errors = 0;

  logic [21:0] exp_q[$];
  logic [39:0] va1[9];
  logic [39:0] va2[9];
  logic [3:0]  vme[9];
  logic [21:0] vex[9];
  logic [21:0] act;

  always #5 clk = ~clk;

  sig_adder_norm dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .max_exp    (max_exp),
    .adder_num1 (adder_num1),
    .adder_num2 (adder_num2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sign   (out_sign),
    .out_exp    (out_exp),
    .out_sig    (out_sig),
    .out_zero   (out_zero),
    .out_ovf    (out_ovf)
  );

  assign act = {out_sign[1], out_exp[7:4], out_sig[7:4], out_zero[1], out_ovf[1],
                out_sign[0], out_exp[3:0], out_sig[3:0], out_zero[0], out_ovf[0]};

  function automatic logic [39:0] ln(input logic [9:0] a, input logic [9:0] b,
                                     input logic [9:0] c, input logic [9:0] d);
    return {d, c, b, a};
  endfunction

  function automatic logic [10:0] rr(input logic s, input logic [3:0] e, input logic [3:0] m,
                                     input logic z, input logic o);
    return {s, e, m, z, o};
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] r);
    checks++;
    if (a !== r) begin
      errors++;
      $display("FAIL %s act=%h req=%h", nm, a, r);
    end
  endtask

  task automatic send(input int i);
    int n;
    n = 0;
    adder_num1 = va1[i];
    adder_num2 = va2[i];
    max_exp    = vme[i];
    in_valid   = 1'b1;
    #1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout vec=%0d act=in_ready_low req=in_ready_high", i);
    end else begin
      exp_q.push_back(vex[i]);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(nm, exp_q.size(), 0);
  endtask

  // Monitor: any valid output must match the scoreboard head; held outputs are rechecked each stall cycle.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst && out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result act=%h req=none", act);
        end else begin
          chk("result", {10'd0, act}, {10'd0, exp_q[0]});
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    max_exp = '0; adder_num1 = '0; adder_num2 = '0;

    va1[0] = ln(10'h040, 10'h040, 10'h040, 10'h040); va2[0] = ln(10'h060, 0, 0, 0); vme[0] = 4'd7;
    vex[0] = {rr(0, 7, 8, 0, 0), rr(0, 9, 0, 0, 0)};
    va1[1] = ln(10'h040, 10'h3C0, 10'h040, 10'h3C0); va2[1] = ln(10'h3C0, 0, 0, 0); vme[1] = 4'd5;
    vex[1] = {rr(1, 5, 0, 0, 0), rr(0, 0, 0, 1, 0)};
    va1[2] = ln(10'h05F, 0, 0, 0); va2[2] = ln(10'h07F, 0, 0, 0); vme[2] = 4'd7;
`ifdef SIG_ADDER_RNE_EN
    vex[2] = {rr(0, 8, 0, 0, 0), rr(0, 7, 8, 0, 0)};
`else
    vex[2] = {rr(0, 7, 15, 0, 0), rr(0, 7, 7, 0, 0)};
`endif
    va1[3] = ln(10'h040, 10'h040, 10'h040, 10'h040);
    va2[3] = ln(10'h3C0, 10'h3C0, 10'h3C0, 10'h3C0); vme[3] = 4'd15;
    vex[3] = {rr(1, 15, 15, 0, 1), rr(0, 15, 15, 0, 1)};
    va1[4] = ln(10'h001, 0, 0, 0); va2[4] = ln(10'h010, 0, 0, 0); vme[4] = 4'd3;
    vex[4] = {rr(0, 1, 0, 0, 0), rr(0, 0, 0, 1, 0)};
    va1[5] = ln(10'h05A, 0, 0, 0); va2[5] = ln(10'h05E, 0, 0, 0); vme[5] = 4'd7;
`ifdef SIG_ADDER_RNE_EN
    vex[5] = {rr(0, 7, 8, 0, 0), rr(0, 7, 6, 0, 0)};
`else
    vex[5] = {rr(0, 7, 7, 0, 0), rr(0, 7, 6, 0, 0)};
`endif
    va1[6] = ln(10'h005, 0, 0, 0); va2[6] = ln(10'h3F8, 0, 0, 0); vme[6] = 4'd3;
    vex[6] = {rr(0, 0, 0, 1, 0), rr(0, 0, 0, 1, 0)};
    va1[7] = ln(10'h005, 0, 0, 0); va2[7] = ln(10'h030, 10'h020, 10'h3F0, 10'h008); vme[7] = 4'd10;
    vex[7] = {rr(0, 10, 2, 0, 0), rr(0, 6, 4, 0, 0)};
    va1[8] = ln(10'h040, 10'h040, 10'h040, 10'h040); va2[8] = ln(10'h3C0, 10'h3C0, 0, 0); vme[8] = 4'd13;
    vex[8] = {rr(1, 14, 0, 0, 0), rr(0, 15, 0, 0, 0)};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_sign", out_sign, 0);
    chk("rst_out_exp", out_exp, 0);
    chk("rst_out_sig", out_sig, 0);
    chk("rst_out_zero", out_zero, 0);
    chk("rst_out_ovf", out_ovf, 0);
    @(negedge clk);

    send(0);
    #1 chk("t1_lat_c1", out_valid, 0);
    @(negedge clk);
    #1 chk("t1_lat_c2", out_valid, 0);
    @(negedge clk);
    #1 chk("t1_lat_c3", out_valid, 1);
    @(negedge clk);

    for (int i = 1; i < 9; i++) send(i);
    drain("drain_directed");

    // Backpressure: pipeline fills, stalls, then releases in order.
    @(negedge clk);
    out_ready = 1'b0;
    fork
      begin
        send(0);
        send(1);
        send(4);
        send(7);
      end
      begin
        repeat (7) @(negedge clk);
        #1;
        chk("t5_in_ready_stalled", in_ready, 0);
        chk("t5_out_valid_stalled", out_valid, 1);
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain("drain_backpressure");

    // Reset with three transactions in flight: none of them may surface.
    @(negedge clk);
    send(2);
    send(3);
    send(5);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_in_ready", in_ready, 1);
    chk("t6_out_exp", out_exp, 0);
    repeat (8) @(negedge clk);

    send(8);
    drain("drain_recovery");
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
